// File: rtl/proc_mem_pkg.sv
// Shared types and constants for the IF/MEM memory port arbiter.
package proc_mem_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_MEM = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    // Winner of an arbitration, held steady for the whole access.
    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              we;
        logic              owner;
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, MEM-stage port, shared RAM port and status of the memory arbiter.
interface mem_port_arbiter_if;
    import proc_mem_pkg::*;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    logic              stall_if;
    logic              stall_mem;
    logic              busy;
    logic              owner;

    modport slave (
        input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_rdata,
        output if_rdata, if_ack, mem_rdata, mem_ack,
        output ram_en, ram_we, ram_addr, ram_wdata,
        output stall_if, stall_mem, busy, owner
    );

    modport master (
        output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, ram_rdata,
        input  if_rdata, if_ack, mem_rdata, mem_ack,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        input  stall_if, stall_mem, busy, owner
    );

endinterface

// File: rtl/mem_arb_timer.sv
// Loadable down-counter timing the RAM access; done flags the final cycle.
module mem_arb_timer #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] count;

    // done is kept registered by predicting the zero of the next count.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            done  <= 1'b1;
        end else if (load) begin
            count <= load_val;
            done  <= (load_val == '0);
        end else begin
            if (count != '0) begin
                count <= count - CNT_W'(1);
            end
            done <= (count <= CNT_W'(1));
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and MEM stages onto one single-port RAM.
// Define MEM_ARB_STARVE_GUARD_EN to bound consecutive MEM grants while IF waits.
module mem_port_arbiter
    import proc_mem_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic                clock,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);

    localparam int unsigned CNT_W = 3;

    generate
        if (MEM_LAT < 1 || MEM_LAT > 7 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_cfg
            $error("mem_port_arbiter: MEM_LAT must be 1..7 and STARVE_MAX 1..15");
        end
    endgenerate

    arb_state_e state;
    arb_state_e state_d;
    grant_t     grant_q;
    grant_t     grant_d;
    logic       mem_req;
    logic       force_if;
    logic       grant_if;
    logic       timer_load;
    logic       timer_done;

    assign mem_req  = bus.mem_rd | bus.mem_wr;
    assign grant_if = bus.if_req & (~mem_req | force_if);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned STARVE_W = 4;

    logic [STARVE_W-1:0] starve_cnt;

    assign force_if = bus.if_req & (starve_cnt == STARVE_W'(STARVE_MAX));

    // Counts MEM grants that leave a pending fetch waiting.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (!bus.if_req || grant_if) begin
                starve_cnt <= '0;
            end else begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end
    end
`else
    assign force_if = 1'b0;
`endif

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        grant_d    = grant_q;
        timer_load = 1'b0;
        unique case (state)
            IDLE: begin
                if (mem_req || bus.if_req) begin
                    state_d    = ACCESS;
                    timer_load = 1'b1;
                    if (grant_if) begin
                        grant_d = '{addr: bus.if_addr, wdata: '0, we: 1'b0, owner: OWNER_IF};
                    end else begin
                        // A simultaneous rd+wr is a write; rd is ignored.
                        grant_d = '{addr: bus.mem_addr, wdata: bus.mem_wdata,
                                    we: bus.mem_wr, owner: OWNER_MEM};
                    end
                end
            end
            ACCESS: begin
                if (timer_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    mem_arb_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clock    (clock),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (CNT_W'(MEM_LAT - 1)),
        .done     (timer_done)
    );

    // Registered strobes and read-data capture, all derived from the next state.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            grant_q       <= '0;
            bus.ram_en    <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.if_ack    <= 1'b0;
            bus.mem_ack   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.if_rdata  <= '0;
            bus.mem_rdata <= '0;
        end else begin
            grant_q     <= grant_d;
            bus.ram_en  <= (state_d == ACCESS);
            bus.ram_we  <= (state_d == ACCESS) & grant_d.we;
            bus.if_ack  <= (state_d == RESP) & (grant_d.owner == OWNER_IF);
            bus.mem_ack <= (state_d == RESP) & (grant_d.owner == OWNER_MEM);
            bus.busy    <= (state_d != IDLE);
            if (state == ACCESS && timer_done && !grant_q.we) begin
                if (grant_q.owner == OWNER_MEM) begin
                    bus.mem_rdata <= bus.ram_rdata;
                end else begin
                    bus.if_rdata <= bus.ram_rdata;
                end
            end
        end
    end

    assign bus.ram_addr  = grant_q.addr;
    assign bus.ram_wdata = grant_q.wdata;
    assign bus.owner     = grant_q.owner;

    assign bus.stall_if  = bus.if_req & ~bus.if_ack;
    assign bus.stall_mem = mem_req & ~bus.mem_ack;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL use one clock, `clock`; reset SHALL be `rst_n`, asynchronous and active-low.
REQ-002 Parameter MEM_LAT, default 2, SHALL set the RAM access wait in cycles; the legal range is 1..7.
REQ-003 Parameter STARVE_MAX, default 3, SHALL set the consecutive MEM grants allowed while IF waits; the legal range is 1..15.
REQ-004 clock  in  1  rising-edge system clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 if_req  in  1  fetch-stage read request, held until if_ack.
REQ-007 if_addr  in  8  fetch address (PC).
REQ-008 if_rdata  out  8  fetched instruction, registered.
REQ-009 if_ack  out  1  one-cycle pulse; if_rdata is valid in that cycle.
REQ-010 mem_rd, mem_wr  in  1 each  MEM-stage read/write request, held until mem_ack.
REQ-011 mem_addr  in  8  data address.
REQ-012 mem_wdata  in  8  store data.
REQ-013 mem_rdata  out  8  load data, registered.
REQ-014 mem_ack  out  1  one-cycle completion pulse.
REQ-015 ram_en, ram_we  out  1 each  shared single-port RAM enable and write strobe.
REQ-016 ram_addr, ram_wdata  out  8 each  RAM address and write data.
REQ-017 ram_rdata  in  8  RAM read data, valid on the last ACCESS cycle.
REQ-018 stall_if, stall_mem  out  1 each  pipeline hold requests to IF and EX/MEM.
REQ-019 busy, owner  out  1 each  busy = FSM not IDLE; owner: 0 = IF, 1 = MEM (last grant).

Function
REQ-020 The FSM SHALL have states IDLE, ACCESS and RESP.
REQ-021 In IDLE, when any request is present, the block SHALL pick a winner, latch its addr/wdata/we, load wait counter = MEM_LAT-1, and go to ACCESS on the next edge.
REQ-022 Default arbitration SHALL be strict: MEM (rd or wr) beats IF.
REQ-023 If mem_rd and mem_wr are both high, the request SHALL be treated as a write and rd ignored.
REQ-024 In ACCESS, ram_en SHALL be 1, ram_we SHALL equal the latched we, and the RAM address/data SHALL be held constant.
REQ-025 ACCESS SHALL last exactly MEM_LAT cycles; on the last cycle the block SHALL capture ram_rdata into the winner's rdata register (reads only) and go to RESP.
REQ-026 In RESP, the block SHALL pulse the winner's ack for exactly 1 cycle, keep ram_en at 0, and return to IDLE.
REQ-027 Request-to-ack latency SHALL be MEM_LAT+1 cycles from the edge that samples the request in IDLE.
REQ-028 Back-to-back accesses SHALL have a gap of one IDLE cycle; peak throughput is 1 access per MEM_LAT+2 cycles.
REQ-029 On a write, the rdata registers SHALL hold their previous value.
REQ-030 If a request drops mid-access, the access SHALL complete and ack SHALL still pulse, with no abort.
REQ-031 stall_if SHALL be if_req & ~if_ack (combinational), and stall_mem SHALL be (mem_rd|mem_wr) & ~mem_ack.
REQ-032 if_ack and mem_ack SHALL never be high in the same cycle.

Reset
REQ-033 While rst_n is 0, at any time including mid-ACCESS, the block SHALL force IDLE, counters 0, ram_en/ram_we/acks 0, ram_addr/ram_wdata/if_rdata/mem_rdata 8'h00, owner 0 and busy 0.
REQ-034 After reset releases, the first arbitration SHALL occur on the first rising edge with rst_n at 1.

Configuration
REQ-035 With macro MEM_ARB_STARVE_GUARD_EN defined, a 4-bit counter SHALL count consecutive MEM grants made while if_req is high; when it equals STARVE_MAX, the next arbitration SHALL grant IF and clear the counter.
REQ-036 With MEM_ARB_STARVE_GUARD_EN defined, an IF grant or an IDLE cycle with if_req at 0 SHALL also clear the counter.
REQ-037 Without MEM_ARB_STARVE_GUARD_EN, no counter logic SHALL exist and strict MEM priority SHALL apply.

Structure
REQ-038 Package proc_mem_pkg SHALL hold the FSM state typedef (IDLE/ACCESS/RESP), constants OWNER_IF=0 and OWNER_MEM=1, and DATA_W=8/ADDR_W=8.
REQ-039 The wait counter SHALL be a sub-module, mem_arb_timer (load, count-down, done).

Verification
REQ-040 MEM_LAT=2, if_req at addr 8'h10, RAM[10]=8'hA5 -> if_ack 3 cycles later with if_rdata=8'hA5, stall_if high for the 3 preceding cycles.
REQ-041 mem_wr at addr 8'h20 with data 8'h3C, then mem_rd at 8'h20 -> write ack, then mem_rdata=8'h3C; if_rdata unchanged.
REQ-042 if_req and mem_rd rise in the same cycle -> MEM is granted first; IF is acked MEM_LAT+2 cycles after mem_ack; the acks never overlap.
REQ-043 GUARD_EN, STARVE_MAX=3, mem_rd held continuously and if_req held -> grant order M,M,M,I,M,M,M,I.
REQ-044 rst_n pulsed low during the 2nd ACCESS cycle -> ram_en drops immediately (async), no ack is issued, and a fresh request after release completes normally.
REQ-045 mem_rd=mem_wr=1 -> a write occurs (ram_we=1) and mem_rdata holds its old value.
